counter_modulo_ud: RTL and testbench
====================================

COUNTER_MODULO_UD -- requirements
Module: counter_modulo_ud

Interface
REQ-001 The block SHALL have parameter MODULO, default 7: count range 0..MODULO-1, legal values 2 and above.
REQ-002 The block SHALL have parameter WIDTH, default $clog2(MODULO): width of out and load_val.
REQ-003 The block SHALL have parameter PRESCALE, default 1: number of enabled cycles per count step, legal values 1 and above.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ce, input, 1 bit: count enable.
REQ-007 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: value applied on load.
REQ-011 The block SHALL have port out, output, WIDTH bits: registered count.
REQ-012 The block SHALL have port tc, output, 1 bit: registered terminal-count pulse.

Function
REQ-013 A step tick SHALL occur on an edge where ce=1 and the prescale count equals PRESCALE-1; the prescale count then returns to 0.
REQ-014 On an edge where ce=1 and no tick occurs, the prescale count SHALL increment.
REQ-015 When PRESCALE=1, every ce=1 edge SHALL be a tick.
REQ-016 When ce=0, out, tc-source state and the prescale count SHALL all hold.
REQ-017 On a tick with up=1: out SHALL go to out+1, except MODULO-1 SHALL wrap to 0.
REQ-018 On a tick with up=0: out SHALL go to out-1, except 0 SHALL wrap to MODULO-1.
REQ-019 tc SHALL be 1 for exactly the one cycle in which out shows the post-wrap value, and 0 otherwise.
REQ-020 tc SHALL follow the same registered timing as out (no combinational path).
REQ-021 Synchronous priority SHALL be clr > load > tick.
REQ-022 clr=1: out SHALL become 0, the prescale count SHALL become 0, and tc SHALL become 0.
REQ-023 load=1 (clr=0): out SHALL become load_val, clamped to MODULO-1 if load_val >= MODULO; the prescale count SHALL become 0 and tc SHALL become 0.
REQ-024 load and clr SHALL act regardless of ce and SHALL never assert tc.
REQ-025 up SHALL be sampled only on tick edges; changing up between ticks SHALL have no other effect.
REQ-026 Latency SHALL be one cycle from tick, clr or load edge to the out/tc update.
REQ-027 out SHALL never hold a value >= MODULO, including when MODULO is not a power of two.

Reset
REQ-028 rst=0 SHALL asynchronously force out=0, tc=0 and prescale count=0, independent of clk.
REQ-029 When rst is released, the first tick SHALL require a full PRESCALE enabled cycles.
REQ-030 Reset SHALL override any in-progress prescale phase.

Structure
REQ-031 No shared package SHALL be required; MODULO, WIDTH and PRESCALE SHALL remain module parameters.
REQ-032 Prescale width SHALL be $clog2(PRESCALE), with a minimum of 1 bit.
REQ-033 The prescaler SHALL be one sub-module, ce_prescaler, with ports clk, rst, ce, clr and tick, and parameter PRESCALE; a clr into ce_prescaler SHALL be driven by clr OR load.
REQ-034 The count/wrap/tc logic SHALL reside in counter_modulo_ud.

Verification
REQ-035 Bench SHALL cover: MODULO=7, PRESCALE=1, up=1, ce=1 from 0 for 8 cycles -> out 1,2,3,4,5,6,0,1; tc=1 only while out=0 after the wrap.
REQ-036 Bench SHALL cover: MODULO=7, up=0, starting from 0 -> out 6,5,4; tc=1 only on the cycle out=6.
REQ-037 Bench SHALL cover: PRESCALE=3, ce=1 continuous -> out increments every 3rd cycle; ce=0 for 5 cycles mid-phase -> out and phase frozen, and the step resumes after the remaining enabled cycles.
REQ-038 Bench SHALL cover: load=1 with load_val=5 -> out=5; load_val=7 -> out=6 (clamped); clr and load together with ce=1 -> out=0 and tc=0.
REQ-039 Bench SHALL cover: out=6 with up=1, wrap pending, load=1 with load_val=2 -> out=2 and tc=0 (load beats tick).
REQ-040 Bench SHALL cover: rst=0 pulsed between clock edges while out=4 -> out=0 and tc=0 immediately; after release with PRESCALE=3, first step after 3 enabled cycles.

Source files
------------

// File: rtl/ce_prescaler.sv
// Enable prescaler: raises tick on every PRESCALE-th enabled cycle.
// clr restarts the phase so the next tick needs a full PRESCALE enabled cycles.
module ce_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    // With PRESCALE=1, LAST is 0 and cnt never leaves 0, so every ce edge ticks.
    assign tick = ce && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ce) begin
            if (cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/counter_modulo_ud.sv
// Up/down modulo-MODULO counter with prescaled enable, sync clear/load
// and a registered terminal-count pulse aligned with the post-wrap value.
module counter_modulo_ud #(
    parameter int MODULO   = 7,
    parameter int WIDTH    = $clog2(MODULO),
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    logic             tick;
    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_up;
    logic [WIDTH-1:0] next_dn;

    // Load/clear both restart the prescale phase.
    ce_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_pre (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .clr (clr | load),
        .tick(tick)
    );

    assign at_top       = (out == MAX);
    assign at_bot       = (out == '0);
    assign next_up      = at_top ? '0 : out + WIDTH'(1);
    assign next_dn      = at_bot ? MAX : out - WIDTH'(1);
    // Compare in 32 bits: MODULO itself may not fit in WIDTH bits.
    assign load_clamped = (32'(load_val) >= MODULO) ? MAX : load_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
            tc  <= 1'b0;
        end else if (clr) begin
            out <= '0;
            tc  <= 1'b0;
        end else if (load) begin
            out <= load_clamped;
            tc  <= 1'b0;
        end else if (tick) begin
            out <= up ? next_up : next_dn;
            tc  <= up ? at_top : at_bot;
        end else begin
            tc  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_modulo_ud.sv
// Directed bench: MODULO=7 counter at PRESCALE=1 (dut a) and PRESCALE=3 (dut b).
module tb_counter_modulo_ud;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       a_ce = 0, a_up = 1, a_clr = 0, a_load = 0;
    logic [2:0] a_lv = '0;
    logic [2:0] a_out;
    logic       a_tc;

    logic       b_ce = 0, b_up = 1, b_clr = 0, b_load = 0;
    logic [2:0] b_lv = '0;
    logic [2:0] b_out;
    logic       b_tc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_modulo_ud #(.MODULO(7), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .ce(a_ce), .up(a_up), .clr(a_clr),
        .load(a_load), .load_val(a_lv), .out(a_out), .tc(a_tc)
    );

    counter_modulo_ud #(.MODULO(7), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .ce(b_ce), .up(b_up), .clr(b_clr),
        .load(b_load), .load_val(b_lv), .out(b_out), .tc(b_tc)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int up_exp[8] = '{1, 2, 3, 4, 5, 6, 0, 1};
    int dn_exp[3] = '{6, 5, 4};
    int pre_exp[6] = '{0, 0, 1, 1, 1, 2};

    initial begin
        #2;
        chk("rst_a_out", a_out, 0);
        chk("rst_a_tc",  a_tc,  0);
        chk("rst_b_out", b_out, 0);
        chk("rst_b_tc",  b_tc,  0);
        #10 rst = 1'b1;
        cyc();

        // Count up through the wrap; tc marks only the wrap to 0.
        a_ce = 1; a_up = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("up_out[%0d]", i), a_out, up_exp[i]);
            chk($sformatf("up_tc[%0d]", i),  a_tc, (i == 6) ? 1 : 0);
        end
        a_ce = 0;

        // Count down from 0: wrap to 6 with tc.
        a_clr = 1; cyc(); a_clr = 0;
        chk("clr_out", a_out, 0);
        a_ce = 1; a_up = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("dn_out[%0d]", i), a_out, dn_exp[i]);
            chk($sformatf("dn_tc[%0d]", i),  a_tc, (i == 0) ? 1 : 0);
        end
        a_ce = 0;

        // ce=0 holds; toggling up between ticks is harmless.
        a_up = 1; cyc(); a_up = 0; cyc();
        chk("hold_out", a_out, 4);
        chk("hold_tc",  a_tc,  0);

        // Load and clamp.
        a_load = 1; a_lv = 3'd5; cyc();
        chk("load5_out", a_out, 5);
        a_lv = 3'd7; cyc();
        chk("load7_clamp", a_out, 6);
        chk("load7_tc", a_tc, 0);
        a_clr = 1; a_ce = 1; cyc();
        chk("clr_load_out", a_out, 0);
        chk("clr_load_tc",  a_tc,  0);
        a_clr = 0; a_ce = 0;

        // Load beats a pending wrap tick.
        a_lv = 3'd6; cyc();
        chk("preload6", a_out, 6);
        a_ce = 1; a_up = 1; a_lv = 3'd2; cyc();
        chk("load_vs_tick_out", a_out, 2);
        chk("load_vs_tick_tc",  a_tc,  0);
        a_load = 0; cyc();
        chk("after_load_step", a_out, 3);
        a_ce = 0;

        // Prescaled counting.
        b_ce = 1; b_up = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("pre_out[%0d]", i), b_out, pre_exp[i]);
        end
        cyc();
        chk("pre_mid_phase", b_out, 2);
        b_ce = 0;
        for (int i = 0; i < 5; i++) cyc();
        chk("pre_frozen_out", b_out, 2);
        chk("pre_frozen_tc",  b_tc,  0);
        b_ce = 1; cyc();
        chk("pre_resume1", b_out, 2);
        cyc();
        chk("pre_resume2", b_out, 3);

        // Reach 4, go mid-phase, then pulse reset between edges.
        cyc(); cyc(); cyc();
        chk("pre_at4", b_out, 4);
        cyc();
        chk("pre_at4_mid", b_out, 4);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out", b_out, 0);
        chk("async_rst_tc",  b_tc,  0);
        #2 rst = 1'b1;
        cyc();
        chk("post_rst_c1", b_out, 0);
        cyc();
        chk("post_rst_c2", b_out, 0);
        cyc();
        chk("post_rst_c3", b_out, 1);
        b_ce = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
